// File: rtl/active_lane_serializer_if.sv
// Warp-request in / single-lane beat out bus for active_lane_serializer.
// The slave modport is the serializer's view; master is the issue-side/consumer view.
interface active_lane_serializer_if #(
  parameter int unsigned NUM_LANE = 16,
  parameter int unsigned LANE_W   = 4,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WID_W    = 3
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [NUM_LANE-1:0]        in_mask_i;
  logic [NUM_LANE*DATA_W-1:0] in_data_i;
  logic [WID_W-1:0]           in_wid_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [LANE_W-1:0]          out_lane_o;
  logic [DATA_W-1:0]          out_data_o;
  logic [WID_W-1:0]           out_wid_o;
  logic [CNT_W-1:0]           out_remain_o;
  logic [CNT_W-1:0]           out_total_o;
  logic                       out_last_o;
  logic                       zero_mask_o;

  modport slave (
    input  in_valid_i, in_mask_i, in_data_i, in_wid_i, out_ready_i,
    output in_ready_o, out_valid_o, out_lane_o, out_data_o, out_wid_o,
           out_remain_o, out_total_o, out_last_o, zero_mask_o
  );

  modport master (
    output in_valid_i, in_mask_i, in_data_i, in_wid_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_lane_o, out_data_o, out_wid_o,
           out_remain_o, out_total_o, out_last_o, zero_mask_o
  );
endinterface

// File: rtl/active_lane_serializer.sv
// Serialises one warp request (mask + per-lane payload) into single-lane beats,
// lowest active lane first; every output is decoded from registered state only.
module active_lane_serializer #(
  parameter int unsigned NUM_LANE = 16,
  parameter int unsigned LANE_W   = 4,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WID_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  active_lane_serializer_if.slave  bus
);

  localparam int unsigned PAYLOAD_W = NUM_LANE * DATA_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [NUM_LANE-1:0]  pend_q, pend_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic [WID_W-1:0]     wid_q, wid_d;
  logic [CNT_W-1:0]     total_q, total_d;
  logic                 zero_q, zero_d;

  logic [NUM_LANE-1:0]  lane_oh;
  logic [LANE_W-1:0]    lane_idx;
  logic [DATA_W-1:0]    lane_data;
  logic [CNT_W-1:0]     remain;

  // Ripple-add population count.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANE-1:0] m);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_LANE); i++) cnt = cnt + CNT_W'(m[i]);
    return cnt;
  endfunction

  // pend_q is all-zero in IDLE, so the beat fields naturally decode to 0 there.
  assign lane_oh = pend_q & (~pend_q + NUM_LANE'(1));
  assign remain  = popcount(pend_q);

  always_comb begin
    lane_idx  = '0;
    lane_data = '0;
    for (int i = int'(NUM_LANE) - 1; i >= 0; i--) begin
      if (pend_q[i]) lane_idx = LANE_W'(i);
    end
    for (int i = 0; i < int'(NUM_LANE); i++) begin
      if (lane_oh[i]) lane_data = lane_data | data_q[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and register-update decode.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    wid_d   = wid_q;
    total_d = total_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          if (|bus.in_mask_i) begin
            pend_d  = bus.in_mask_i;
            data_d  = bus.in_data_i;
            wid_d   = bus.in_wid_i;
            total_d = popcount(bus.in_mask_i);
            state_d = BUSY;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.out_ready_i) begin
          pend_d = pend_q & ~lane_oh;
          if (remain == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      wid_q   <= '0;
      total_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      wid_q   <= wid_d;
      total_q <= total_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready_o   = (state_q == IDLE);
  assign bus.out_valid_o  = (state_q == BUSY);
  assign bus.out_lane_o   = lane_idx;
  assign bus.out_data_o   = lane_data;
  assign bus.out_wid_o    = wid_q;
  assign bus.out_remain_o = remain;
  assign bus.out_total_o  = total_q;
  assign bus.out_last_o   = (remain == CNT_W'(1));
  assign bus.zero_mask_o  = zero_q;

endmodule

// File: tb/tb_active_lane_serializer.sv
// Scoreboard bench for active_lane_serializer: expected beats are queued when a
// request is driven and popped as handshakes occur.
module tb_active_lane_serializer;

  localparam int unsigned NUM_LANE = 16;
  localparam int unsigned LANE_W   = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WID_W    = 3;
  localparam int unsigned PAY_W    = NUM_LANE * DATA_W;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] data;
    logic [WID_W-1:0]  wid;
    logic [CNT_W-1:0]  remain;
    logic [CNT_W-1:0]  total;
    logic              last;
  } beat_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  beat_t exp_q[$];

  active_lane_serializer_if #(
    .NUM_LANE(NUM_LANE), .LANE_W(LANE_W), .CNT_W(CNT_W), .DATA_W(DATA_W), .WID_W(WID_W)
  ) bus ();

  active_lane_serializer #(
    .NUM_LANE(NUM_LANE), .LANE_W(LANE_W), .CNT_W(CNT_W), .DATA_W(DATA_W), .WID_W(WID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t obs_beat();
    beat_t b;
    b.lane   = bus.out_lane_o;
    b.data   = bus.out_data_o;
    b.wid    = bus.out_wid_o;
    b.remain = bus.out_remain_o;
    b.total  = bus.out_total_o;
    b.last   = bus.out_last_o;
    return b;
  endfunction

  // Reference model: one beat per set bit, ascending lane, remain counting down.
  task automatic push_expected(input logic [NUM_LANE-1:0] m, input logic [PAY_W-1:0] d,
                               input logic [WID_W-1:0] w);
    int cnt;
    int rem;
    beat_t b;
    cnt = 0;
    for (int k = 0; k < int'(NUM_LANE); k++) if (m[k]) cnt++;
    rem = cnt;
    for (int k = 0; k < int'(NUM_LANE); k++) begin
      if (m[k]) begin
        b.lane   = LANE_W'(k);
        b.data   = d[k*DATA_W +: DATA_W];
        b.wid    = w;
        b.remain = CNT_W'(rem);
        b.total  = CNT_W'(cnt);
        b.last   = (rem == 1);
        exp_q.push_back(b);
        rem--;
      end
    end
  endtask

  // Drive one request for a single accepting edge, queueing its expected beats.
  task automatic send(input logic [NUM_LANE-1:0] m, input logic [PAY_W-1:0] d,
                      input logic [WID_W-1:0] w);
    push_expected(m, d, w);
    bus.in_valid_i = 1'b1;
    bus.in_mask_i  = m;
    bus.in_data_i  = d;
    bus.in_wid_i   = w;
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.zero_mask_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got rdy/vld/last/zero=%b want 1000",
               {bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.zero_mask_o});
    end
    total++;
    if (obs_beat() !== beat_t'(0)) begin
      bad++;
      $display("FAIL reset_fields got %h want 0", obs_beat());
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [PAY_W-1:0] d;
    beat_t e;
    d = '0;
    d[31:0] = 32'hA5A5_0000;
    bus.out_ready_i = 1'b1;
    send(16'h0001, d, 3'd1);
    e = exp_q.pop_front();
    total++;
    if (!(bus.out_valid_o === 1'b1 && obs_beat() === e)) begin
      bad++;
      $display("FAIL single_beat got vld=%b %h want vld=1 %h", bus.out_valid_o, obs_beat(), e);
    end
    tick();
    total++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o} !== 3'b100) begin
      bad++;
      $display("FAIL single_idle got rdy/vld/last=%b want 100",
               {bus.in_ready_o, bus.out_valid_o, bus.out_last_o});
    end
    total++;
    if ({bus.out_lane_o, bus.out_data_o, bus.out_remain_o, bus.out_total_o, bus.out_wid_o} !==
        {4'd0, 32'd0, 5'd0, 5'd1, 3'd1}) begin
      bad++;
      $display("FAIL single_idle_fields got lane=%0d data=%h rem=%0d tot=%0d wid=%0d want 0 0 0 1 1",
               bus.out_lane_o, bus.out_data_o, bus.out_remain_o, bus.out_total_o, bus.out_wid_o);
    end
  endtask

  task automatic test_sparse();
    logic [PAY_W-1:0] d;
    beat_t e;
    int guard;
    for (int k = 0; k < int'(NUM_LANE); k++) d[k*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(k * 32'h111);
    bus.out_ready_i = 1'b1;
    send(16'h8421, d, 3'd5);
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        e = exp_q.pop_front();
        total++;
        if (obs_beat() !== e) begin
          bad++;
          $display("FAIL sparse_beat got %h want %h", obs_beat(), e);
        end
      end
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sparse_timeout got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_full_toggle();
    logic [PAY_W-1:0] d;
    beat_t e;
    beat_t held;
    int guard;
    int hs;
    for (int k = 0; k < int'(NUM_LANE); k++) d[k*DATA_W +: DATA_W] = $urandom;
    bus.out_ready_i = 1'b1;
    send(16'hFFFF, d, 3'd7);
    guard = 0;
    hs = 0;
    while (exp_q.size() != 0 && guard < 80) begin
      bus.out_ready_i = guard[0] ? 1'b0 : 1'b1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        e = exp_q.pop_front();
        hs++;
        total++;
        if (obs_beat() !== e) begin
          bad++;
          $display("FAIL full_beat got %h want %h", obs_beat(), e);
        end
        tick();
      end else begin
        held = obs_beat();
        tick();
        total++;
        if (obs_beat() !== held || bus.out_valid_o !== 1'b1) begin
          bad++;
          $display("FAIL full_stall got vld=%b %h want vld=1 %h", bus.out_valid_o, obs_beat(), held);
        end
      end
      guard++;
    end
    bus.out_ready_i = 1'b1;
    total++;
    if (exp_q.size() != 0 || hs != 16 || bus.out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL full_end got left=%0d hs=%0d vld=%b want 0 16 0", exp_q.size(), hs, bus.out_valid_o);
      exp_q.delete();
    end
  endtask

  task automatic test_zero_mask();
    bus.out_ready_i = 1'b1;
    send(16'h0000, '0, 3'd2);
    total++;
    if ({bus.zero_mask_o, bus.out_valid_o, bus.in_ready_o} !== 3'b101) begin
      bad++;
      $display("FAIL zero_pulse got zero/vld/rdy=%b want 101",
               {bus.zero_mask_o, bus.out_valid_o, bus.in_ready_o});
    end
    tick();
    total++;
    if ({bus.zero_mask_o, bus.out_valid_o, bus.in_ready_o} !== 3'b001) begin
      bad++;
      $display("FAIL zero_after got zero/vld/rdy=%b want 001",
               {bus.zero_mask_o, bus.out_valid_o, bus.in_ready_o});
    end
  endtask

  // A (2 lanes) accepted at cycle 0; beats at 1,2; B accepted at 3; beats at 4,5; idle at 6.
  task automatic test_back_to_back();
    logic [PAY_W-1:0] da;
    logic [PAY_W-1:0] db;
    beat_t e;
    for (int k = 0; k < int'(NUM_LANE); k++) begin
      da[k*DATA_W +: DATA_W] = 32'hAA00_0000 | 32'(k);
      db[k*DATA_W +: DATA_W] = 32'hBB00_0000 | 32'(k);
    end
    bus.out_ready_i = 1'b1;
    push_expected(16'h0003, da, 3'd2);
    push_expected(16'h0110, db, 3'd6);
    bus.in_valid_i = 1'b1;
    bus.in_mask_i  = 16'h0003;
    bus.in_data_i  = da;
    bus.in_wid_i   = 3'd2;
    tick();
    bus.in_mask_i = 16'h0110;
    bus.in_data_i = db;
    bus.in_wid_i  = 3'd6;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      total++;
      if (bus.in_ready_o !== (cyc == 3 || cyc == 6)) begin
        bad++;
        $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, bus.in_ready_o, (cyc == 3 || cyc == 6));
      end
      if (bus.out_valid_o && bus.out_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (obs_beat() !== e) begin
          bad++;
          $display("FAIL b2b_beat cyc=%0d got %h want %h", cyc, obs_beat(), e);
        end
      end
      tick();
      if (cyc == 3) bus.in_valid_i = 1'b0;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL b2b_left got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [PAY_W-1:0] d;
    beat_t e;
    int guard;
    for (int k = 0; k < int'(NUM_LANE); k++) d[k*DATA_W +: DATA_W] = 32'hC0DE_0000 | 32'(k);
    bus.out_ready_i = 1'b1;
    send(16'h000F, d, 3'd3);
    for (int b = 0; b < 2; b++) begin
      e = exp_q.pop_front();
      total++;
      if (!(bus.out_valid_o === 1'b1 && obs_beat() === e)) begin
        bad++;
        $display("FAIL rmid_beat got vld=%b %h want vld=1 %h", bus.out_valid_o, obs_beat(), e);
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.zero_mask_o} !== 4'b1000) begin
      bad++;
      $display("FAIL rmid_ctrl got rdy/vld/last/zero=%b want 1000",
               {bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.zero_mask_o});
    end
    total++;
    if (obs_beat() !== beat_t'(0)) begin
      bad++;
      $display("FAIL rmid_fields got %h want 0", obs_beat());
    end
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    send(16'h00C0, d, 3'd4);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        e = exp_q.pop_front();
        total++;
        if (obs_beat() !== e) begin
          bad++;
          $display("FAIL rmid_next got %h want %h", obs_beat(), e);
        end
      end
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL rmid_timeout got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_mask_i   = '0;
    bus.in_data_i   = '0;
    bus.in_wid_i    = '0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_single();
    test_sparse();
    test_full_toggle();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
